// File: rtl/instr_mem_bank.sv
// Banked instruction memory: registered fetch port with fault flag, plus a
// byte-serial loader that writes one program bank at run time.
module instr_mem_bank #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PROG_SIZE = 32,
  parameter int unsigned NUM_PROG  = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        fetch_req,
  input  logic [ADDR_W-1:0]           address,
  input  logic [$clog2(NUM_PROG)-1:0] prog_sel,
  output logic [DATA_W-1:0]           instrucao,
  output logic                        instr_valid,
  output logic                        addr_fault,
  input  logic                        load_start,
  input  logic [7:0]                  load_byte,
  input  logic                        load_byte_valid,
  input  logic                        load_end,
  output logic                        load_ready,
  output logic                        load_done,
  output logic                        load_error,
  output logic                        busy
);

  localparam int unsigned BPW   = DATA_W / 8;
  localparam int unsigned BC_W  = $clog2(BPW + 1);
  localparam int unsigned WP_W  = $clog2(PROG_SIZE);
  localparam int unsigned SEL_W = $clog2(NUM_PROG);
  localparam int unsigned DEPTH = NUM_PROG * PROG_SIZE;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

  state_t            state;
  logic [SEL_W-1:0]  bank;
  logic [WP_W-1:0]   wp;
  logic [BC_W-1:0]   bc;
  logic [DATA_W-1:0] asm_word;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              fetch_fault_c;
  logic [IDX_W-1:0]  fetch_idx_c;
  logic              wr_en_c;
  logic [IDX_W-1:0]  wr_idx_c;
  logic [DATA_W-1:0] asm_next_c;
  logic              word_last_byte_c;

  // Fetch fault: out-of-range offset, or the bank currently being written.
  always_comb begin
    fetch_fault_c = (32'(address) >= PROG_SIZE) ||
                    ((state == LOAD) && (bank == prog_sel));
    fetch_idx_c   = IDX_W'(prog_sel) * IDX_W'(PROG_SIZE) + IDX_W'(address);
  end

  // Byte assembly: new byte enters at the LSB so the first byte ends at the MSB.
  always_comb begin
    asm_next_c       = DATA_W'({asm_word, load_byte});
    word_last_byte_c = (bc == BC_W'(BPW - 1));
    wr_en_c          = (state == LOAD) && !load_end && load_byte_valid && word_last_byte_c;
    wr_idx_c         = IDX_W'(bank) * IDX_W'(PROG_SIZE) + IDX_W'(wp);
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_en_c) mem[wr_idx_c] <= asm_next_c;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instrucao   <= '0;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else begin
      instr_valid <= fetch_req;
      addr_fault  <= fetch_req && fetch_fault_c;
      if (fetch_req) instrucao <= fetch_fault_c ? NOP_WORD : mem[fetch_idx_c];
    end
  end

  // Loader FSM with registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bank       <= '0;
      wp         <= '0;
      bc         <= '0;
      asm_word   <= '0;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            bank       <= prog_sel;
            wp         <= '0;
            bc         <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (load_end) begin
            bc         <= '0;
            load_ready <= 1'b0;
            if ((bc == '0) && !load_byte_valid) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              state      <= ERR;
              load_error <= 1'b1;
            end
          end else if (load_byte_valid) begin
            asm_word <= asm_next_c;
            if (word_last_byte_c) begin
              bc <= '0;
              wp <= wp + WP_W'(1);
              if (wp == WP_W'(PROG_SIZE - 1)) begin
                state      <= DONE;
                load_ready <= 1'b0;
                load_done  <= 1'b1;
              end
            end else begin
              bc <= bc + BC_W'(1);
            end
          end
        end
        DONE, ERR: begin
          state      <= IDLE;
          load_done  <= 1'b0;
          load_error <= 1'b0;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_bank.sv
// Scoreboard bench for instr_mem_bank: random fetches against a bank/word
// array model, plus directed loader scenarios (full, truncated, early end, reset).
module tb_instr_mem_bank;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [9:0]  address = '0;
  logic [1:0]  prog_sel = '0;
  logic [31:0] instrucao;
  logic        instr_valid;
  logic        addr_fault;
  logic        load_start = 1'b0;
  logic [7:0]  load_byte = '0;
  logic        load_byte_valid = 1'b0;
  logic        load_end = 1'b0;
  logic        load_ready;
  logic        load_done;
  logic        load_error;
  logic        busy;

  instr_mem_bank dut (
    .clock(clock), .reset_n(reset_n), .fetch_req(fetch_req), .address(address),
    .prog_sel(prog_sel), .instrucao(instrucao), .instr_valid(instr_valid),
    .addr_fault(addr_fault), .load_start(load_start), .load_byte(load_byte),
    .load_byte_valid(load_byte_valid), .load_end(load_end), .load_ready(load_ready),
    .load_done(load_done), .load_error(load_error), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [4][32];
  bit          loading = 0;
  int          load_bank = 0;
  int          checks = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue_fetch(input int bank, input int addr);
    exp_t e;
    e.fault = (addr >= 32) || (loading && bank == load_bank);
    e.data  = e.fault ? 32'h0 : model_mem[bank][addr];
    prog_sel  = 2'(bank);
    address   = 10'(addr);
    fetch_req = 1'b1;
    sb.push_back(e);
    @(negedge clock);
    fetch_req = 1'b0;
  endtask

  task automatic start_load(input int bank);
    prog_sel   = 2'(bank);
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    loading    = 1;
    load_bank  = bank;
    check("load_ready_on_start", 32'(load_ready), 32'd1);
    check("busy_on_start", 32'(busy), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_byte       = b;
    load_byte_valid = 1'b1;
    @(negedge clock);
    load_byte_valid = 1'b0;
  endtask

  task automatic load_word(input int bank, input int wp, input logic [31:0] word);
    for (int i = 0; i < 4; i++) send_byte(word[31-8*i -: 8]);
    model_mem[bank][wp] = word;
    if (wp == 31) loading = 0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a fetch result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (load_done) done_cnt++;
      if (load_error) err_cnt++;
      if (instr_valid) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid: got instrucao %h expected no result", instrucao);
        end else begin
          e = sb.pop_front();
          check("fetch_data", instrucao, e.data);
          check("fetch_fault", 32'(addr_fault), 32'(e.fault));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, e0, a;
    logic [31:0] w0;

    // Reset held 3 cycles; outputs must be zero.
    repeat (3) @(negedge clock);
    check("rst_instrucao", instrucao, 32'h0);
    check("rst_outputs", {25'b0, instr_valid, addr_fault, load_ready, load_done, load_error, busy, 1'b0}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Full load of bank 1.
    start_load(1);
    for (int k = 0; k < 32; k++) begin
      if (k == 31) check("no_early_done", 32'(done_cnt), 32'd0);
      load_word(1, k, 32'h1000_0000 + 32'(k));
    end
    check("done_after_128", 32'(load_done), 32'd1);
    check("ready_low_in_done", 32'(load_ready), 32'd0);
    issue_fetch(1, 31);  // sampled while FSM is in DONE
    check("done_one_cycle", 32'(load_done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    for (int k = 0; k < 32; k++) issue_fetch(1, k);

    // Out-of-range fetches.
    issue_fetch(0, 32);
    issue_fetch(2, 1023);

    // Full load of bank 2, then truncated reload.
    start_load(2);
    for (int k = 0; k < 32; k++) load_word(2, k, 32'h2000_0000 + 32'(k));
    @(negedge clock);
    start_load(2);
    load_word(2, 0, 32'hAABB_CCDD);
    send_byte(8'h11);
    send_byte(8'h22);
    load_end = 1'b1;
    @(negedge clock);
    load_end = 1'b0;
    loading  = 0;
    check("trunc_error", 32'(load_error), 32'd1);
    check("trunc_no_done", 32'(load_done), 32'd0);
    for (int k = 0; k < 3; k++) issue_fetch(2, k);

    // Load bank 3 while fetching bank 1 every cycle.
    start_load(3);
    fork
      for (int k = 0; k < 32; k++) load_word(3, k, $urandom);
      for (int c = 0; c < 100; c++) begin
        if (c == 40) issue_fetch(3, 7);
        else issue_fetch(1, c % 32);
      end
    join
    check("concurrent_done", 32'(load_done), 32'd1);
    for (int k = 0; k < 32; k += 5) issue_fetch(3, k);

    // Reset in the middle of loading bank 0.
    start_load(0);
    w0 = $urandom;
    load_word(0, 0, w0);
    send_byte(8'h5A);
    prog_sel  = 2'd1;
    address   = 10'd5;
    fetch_req = 1'b1;
    sb.push_back('{data: 32'h1000_0005, fault: 1'b0});
    send_byte(8'hA5);
    fetch_req = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    #1 reset_n = 1'b0;
    loading = 0;
    #1;
    check("midrst_instrucao", instrucao, 32'h0);
    check("midrst_outputs", {25'b0, instr_valid, addr_fault, load_ready, load_done, load_error, busy, 1'b0}, 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_no_pulse", 32'(done_cnt + err_cnt), 32'(d0 + e0));
    issue_fetch(0, 0);

    // Early clean end after three words of bank 0.
    start_load(0);
    for (int k = 0; k < 3; k++) load_word(0, k, $urandom);
    load_end = 1'b1;
    @(negedge clock);
    load_end = 1'b0;
    loading  = 0;
    check("early_done", 32'(load_done), 32'd1);
    check("early_no_error", 32'(load_error), 32'd0);
    for (int k = 0; k < 3; k++) issue_fetch(0, k);

    // Random fetch mix over known words and out-of-range addresses.
    for (int n = 0; n < 60; n++) begin
      int b;
      b = int'($urandom_range(0, 3));
      a = int'($urandom_range(0, 40));
      if (b == 0 && a < 32) a = a % 3;
      issue_fetch(b, a);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("total_done_pulses", 32'(done_cnt), 32'd4);
    check("total_error_pulses", 32'(err_cnt), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
